mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have the parameter MULT_CYCLES, default 5, giving the busy cycles for mult/multu.
REQ-002 The block SHALL have the parameter DIV_CYCLES, default 10, giving the busy cycles for div/divu.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port SRCA, input, 32 bits: forwarded E-stage rs operand.
REQ-006 The block SHALL have the port SRCB, input, 32 bits: forwarded E-stage rt operand.
REQ-007 The block SHALL have the port MDUop, input, 4 bits, with this encoding:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mthi
- 6 mtlo
- 7..15 none
REQ-008 The block SHALL have the port Start, input, 1 bit: the E-stage instruction is mult/multu/div/divu; qualifies MDUop 1..4.
REQ-009 The block SHALL have the port Busy, output, 1 bit: an operation is in flight.
REQ-010 The block SHALL have the port HI, output, 32 bits: the architectural HI register.
REQ-011 The block SHALL have the port LO, output, 32 bits: the architectural LO register.

Function
REQ-012 A start SHALL be accepted on edge k when Start=1, Busy=0, reset=0, and MDUop is in 1..4.
REQ-013 On acceptance the block SHALL capture the full 64-bit result into internal temp registers {tHI,tLO} and load the counter with N (MULT_CYCLES or DIV_CYCLES).
REQ-014 Busy SHALL be 1 in the N cycles following edge k and 0 otherwise.
REQ-015 Each edge with counter>1 SHALL decrement the counter.
REQ-016 On the edge where counter==1, the block SHALL set HI<=tHI, LO<=tLO and counter<=0.
- New HI/LO become visible in the same cycle Busy falls (edge k+N).
REQ-017 mult SHALL compute the signed 32x32 product; multu the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-018 div SHALL compute signed division: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-019 divu SHALL compute unsigned division: LO = quotient, HI = remainder.
REQ-020 Division with SRCB=0 SHALL leave HI/LO unchanged at completion, while Busy still runs the full DIV_CYCLES.
REQ-021 Signed div with 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo (MDUop 5/6) with Busy=0 SHALL write SRCA into HI/LO on the same edge, with zero latency and no Busy.
REQ-023 Start, mthi and mtlo SHALL be ignored while Busy=1; the in-flight operation SHALL be unaffected.
REQ-024 Start=1 with MDUop outside 1..4 SHALL be ignored.
REQ-025 The external hazard unit SHALL stall D whenever a D-stage MDU instruction (mult/div/mthi/mtlo/mfhi/mflo) sees (Start=1 or Busy=1).
- The block itself SHALL perform no stalling or flushing.
REQ-026 The HI and LO outputs SHALL come directly from the architectural registers; temp values SHALL never be exposed on them.

Reset
REQ-027 When reset=1 at an edge, the block SHALL set HI=0, LO=0, counter=0, Busy=0 and temp registers=0.
REQ-028 Reset SHALL take priority over every operation, including mid-operation; an aborted operation SHALL never write HI/LO.
REQ-029 A Start asserted in the same cycle as reset SHALL be discarded.

Verification
REQ-030 The bench SHALL check mult: SRCA=0xFFFFFFFD, SRCB=5, Start -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-031 The bench SHALL check multu: SRCA=0xFFFFFFFF, SRCB=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 The bench SHALL check div: SRCA=0xFFFFFFF9 (-7), SRCB=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-033 The bench SHALL check writes during busy: mthi SRCA=0x1234 at cycle 3 of a mult, plus a second Start at cycle 4 -> both ignored, and HI/LO equal the first mult's result at completion.
REQ-034 The bench SHALL check reset mid-operation: div started, reset at cycle 6 -> HI=LO=0, Busy=0 next cycle, and no later HI/LO update.
REQ-035 The bench SHALL check back-to-back operations: mtlo 0xABCD with Busy=0 -> LO=0xABCD the next cycle; then a mult with Start the following cycle is accepted normally.

Source files
------------

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO and a fixed busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic [3:0]  MDUop,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d, cnt_q, cnt_d;
  logic        acc, smul, sdiv, sa, sb;
  logic [31:0] ma, mb, dv, uq, ur, q, r;
  logic [63:0] prod, res;
  assign Busy = cnt_q != 32'd0;
  assign HI   = hi_q;
  assign LO   = lo_q;
  // Signed ops run on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN, remainder 0.
  always_comb begin
    acc   = Start && !Busy && MDUop inside {[4'd1:4'd4]};
    smul  = MDUop == 4'd1;
    sdiv  = MDUop == 4'd3;
    prod  = {{32{smul & SRCA[31]}}, SRCA} * {{32{smul & SRCB[31]}}, SRCB};
    sa    = sdiv & SRCA[31];
    sb    = sdiv & SRCB[31];
    ma    = sa ? -SRCA : SRCA;
    mb    = sb ? -SRCB : SRCB;
    dv    = mb == 32'd0 ? 32'd1 : mb;
    uq    = ma / dv;
    ur    = ma % dv;
    q     = (sa ^ sb) ? -uq : uq;
    r     = sa ? -ur : ur;
    res   = MDUop <= 4'd2 ? prod : (SRCB == 32'd0 ? {hi_q, lo_q} : {r, q});
    hi_d  = hi_q;
    lo_d  = lo_q;
    thi_d = thi_q;
    tlo_d = tlo_q;
    cnt_d = cnt_q;
    if (acc) begin
      {thi_d, tlo_d} = res;
      cnt_d = MDUop <= 4'd2 ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
    end else if (cnt_q == 32'd1) begin
      hi_d  = thi_q;
      lo_d  = tlo_q;
      cnt_d = 32'd0;
    end else if (cnt_q > 32'd1) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      hi_d = MDUop == 4'd5 ? SRCA : hi_q;
      lo_d = MDUop == 4'd6 ? SRCA : lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      thi_q <= '0;
      tlo_q <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
